// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter.
// Accepts one character per n_cs/n_rd handshake and sends it on tx as
// start bit, DATA_BITS data bits (LSB or MSB first), optional odd/even
// parity bit and STOP_BITS stop bits. Each bit lasts CDIV clocks.
// Ports:
//   clk    - clock, rising edge
//   n_rst  - asynchronous active-low reset
//   n_cs   - active-low request, data valid
//   data   - character, sampled only at accept
//   n_rd   - active-low ready (registered)
//   tx     - serial line, idles high (registered)
//   busy   - frame in progress (registered)
module uart_tx_cfg #(
    parameter int CDIV      = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 n_cs,
    input  logic [DATA_BITS-1:0] data,
    output logic                 n_rd,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = (CDIV > 2) ? $clog2(CDIV) : 1;

    if (CDIV < 2) begin : g_chk_cdiv
        $error("uart_tx_cfg: CDIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 n_rd_q, n_rd_d;
    logic                 busy_q, busy_d;

    logic                 bit_end;
    logic                 next_bit;
    logic [DATA_BITS-1:0] shifted;

    assign bit_end  = (cnt_q == CW'(CDIV - 1));
    assign next_bit = (MSB_FIRST != 0) ? shreg_q[DATA_BITS-1] : shreg_q[0];
    assign shifted  = (MSB_FIRST != 0) ? {shreg_q[DATA_BITS-2:0], 1'b0}
                                       : {1'b0, shreg_q[DATA_BITS-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        n_rd_d  = n_rd_q;
        busy_d  = busy_q;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!n_cs) begin
                    state_d = S_START;
                    shreg_d = data;
                    idx_d   = '0;
                    par_d   = 1'b0;
                    tx_d    = 1'b0;
                    n_rd_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = next_bit;
                    par_d   = next_bit;
                    shreg_d = shifted;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == 4'(DATA_BITS - 1)) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = (PARITY == 2) ? par_q : ~par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        tx_d    = next_bit;
                        par_d   = par_q ^ next_bit;
                        shreg_d = shifted;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == 4'(STOP_BITS - 1)) begin
                        idx_d = '0;
                        // The frame-end edge doubles as the first IDLE edge so a
                        // pending request starts with no extra idle cycle.
                        if (!n_cs) begin
                            state_d = S_START;
                            shreg_d = data;
                            par_d   = 1'b0;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            n_rd_d  = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            n_rd_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            n_rd_q  <= n_rd_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign n_rd = n_rd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: bench for uart_tx_cfg over several parameter sets.
// Each configuration gets its own DUT, stimulus process, expected-frame
// queue and line monitor. Expected frames are built from the character
// and the frame format; the monitor checks every clock of every bit.
module tb_uart_tx_cfg;

    localparam int NCFG = 7;
    localparam int CFG_CDIV [NCFG] = '{4, 4, 4, 4, 4, 3, 2};
    localparam int CFG_DB   [NCFG] = '{8, 8, 8, 7, 8, 9, 5};
    localparam int CFG_PAR  [NCFG] = '{0, 2, 1, 2, 0, 1, 2};
    localparam int CFG_SB   [NCFG] = '{1, 1, 1, 2, 1, 2, 1};
    localparam int CFG_MSB  [NCFG] = '{0, 0, 0, 0, 1, 1, 0};

    typedef struct {
        logic [15:0] lv;
        int          n;
        bit          chained;
    } frame_t;

    logic            clk = 1'b0;
    logic            rstn   [NCFG];
    logic            cs_n   [NCFG];
    logic [8:0]      data_w [NCFG];
    bit              done   [NCFG];
    logic [NCFG-1:0] tx_w;
    logic [NCFG-1:0] n_rd_w;
    logic [NCFG-1:0] busy_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string nm, input int g, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cfg%0d: actual %0h required %0h", nm, g, act, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge with n_rd low.
    task automatic wait_ready(input int g, input int bound);
        int n;
        n = 0;
        while (n_rd_w[g] !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(n_rd_w[g] === 1'b0, "ready_wait", g, n, bound);
    endtask

    // Line levels of one frame, one entry per bit time.
    function automatic frame_t mk_frame(input int db, input int par, input int sb, input int msb,
                                        input logic [8:0] d, input bit chained);
        frame_t f;
        int     n;
        int     ones;
        f.lv      = '1;
        f.chained = chained;
        ones      = 0;
        f.lv[0]   = 1'b0;
        n         = 1;
        for (int i = 0; i < db; i++) begin
            int k;
            k       = (msb != 0) ? db - 1 - i : i;
            f.lv[n] = d[k];
            ones    = ones + int'(d[k]);
            n++;
        end
        if (par != 0) begin
            f.lv[n] = (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            f.lv[n] = 1'b1;
            n++;
        end
        f.n = n;
        return f;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int C = CFG_CDIV[g];
        localparam int D = CFG_DB[g];
        localparam int P = CFG_PAR[g];
        localparam int S = CFG_SB[g];
        localparam int M = CFG_MSB[g];
        localparam int F = C * (1 + D + ((P != 0) ? 1 : 0) + S);
        localparam logic [8:0] MASK = 9'((1 << D) - 1);

        frame_t q[$];

        uart_tx_cfg #(
            .CDIV      (C),
            .DATA_BITS (D),
            .PARITY    (P),
            .STOP_BITS (S),
            .MSB_FIRST (M)
        ) u_dut (
            .clk   (clk),
            .n_rst (rstn[g]),
            .n_cs  (cs_n[g]),
            .data  (data_w[g][D-1:0]),
            .n_rd  (n_rd_w[g]),
            .tx    (tx_w[g]),
            .busy  (busy_w[g])
        );

        initial begin : stim
            logic [8:0] d;
            int         k3;
            done[g]   = 1'b0;
            cs_n[g]   = 1'b0;
            data_w[g] = '0;
            rstn[g]   = 1'b0;
            repeat (3) @(negedge clk);
            check(tx_w[g] === 1'b1, "rst_tx", g, int'(tx_w[g]), 1);
            check(n_rd_w[g] === 1'b0, "rst_n_rd", g, int'(n_rd_w[g]), 0);
            check(busy_w[g] === 1'b0, "rst_busy", g, int'(busy_w[g]), 0);

            // Release with a request pending: frame starts on the first edge.
            d = (D == 7) ? 9'h74 : (9'h53 & MASK);
            q.push_back(mk_frame(D, P, S, M, d, 1'b0));
            data_w[g] = d;
            rstn[g]   = 1'b1;
            @(negedge clk);
            cs_n[g]   = 1'b1;
            data_w[g] = 9'($urandom);

            for (int i = 0; i < 4; i++) begin
                wait_ready(g, 4 * F);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                d = 9'($urandom) & MASK;
                q.push_back(mk_frame(D, P, S, M, d, 1'b0));
                cs_n[g]   = 1'b0;
                data_w[g] = d;
                @(negedge clk);
                cs_n[g]   = 1'b1;
                data_w[g] = 9'($urandom);
            end

            // Back-to-back with n_cs held low and data scrambled mid-frame.
            wait_ready(g, 4 * F);
            for (int i = 0; i < 3; i++) begin
                d = (i == 0) ? (9'h53 & MASK) : (i == 1) ? (9'h74 & MASK) : (9'($urandom) & MASK);
                q.push_back(mk_frame(D, P, S, M, d, i != 0));
                cs_n[g]   = 1'b0;
                data_w[g] = d;
                if (i == 2) begin
                    @(negedge clk);
                    cs_n[g]   = 1'b1;
                    data_w[g] = 9'($urandom);
                end else begin
                    repeat (F) begin
                        @(negedge clk);
                        data_w[g] = 9'($urandom);
                    end
                end
            end

            // Reset during data bit 3, which is forced to 0 so tx must visibly rise.
            wait_ready(g, 4 * F);
            d  = 9'($urandom) & MASK;
            k3 = (M != 0) ? D - 4 : 3;
            d[k3] = 1'b0;
            q.push_back(mk_frame(D, P, S, M, d, 1'b0));
            cs_n[g]   = 1'b0;
            data_w[g] = d;
            @(negedge clk);
            cs_n[g] = 1'b1;
            repeat (4 * C) @(negedge clk);
            check(tx_w[g] === 1'b0, "bit3_before_rst", g, int'(tx_w[g]), 0);
            rstn[g] = 1'b0;
            #1;
            check(tx_w[g] === 1'b1, "midrst_tx", g, int'(tx_w[g]), 1);
            check(n_rd_w[g] === 1'b0, "midrst_n_rd", g, int'(n_rd_w[g]), 0);
            check(busy_w[g] === 1'b0, "midrst_busy", g, int'(busy_w[g]), 0);
            repeat (2) @(negedge clk);
            rstn[g] = 1'b1;
            @(negedge clk);
            check(n_rd_w[g] === 1'b0, "post_rst_n_rd", g, int'(n_rd_w[g]), 0);
            d = 9'($urandom) & MASK;
            q.push_back(mk_frame(D, P, S, M, d, 1'b0));
            cs_n[g]   = 1'b0;
            data_w[g] = d;
            @(negedge clk);
            cs_n[g]   = 1'b1;
            data_w[g] = 9'($urandom);

            wait_ready(g, 4 * F);
            repeat (2) @(negedge clk);
            check(q.size() == 0, "queue_drained", g, q.size(), 0);
            done[g] = 1'b1;
        end

        initial begin : mon
            frame_t     e;
            bit         skip;
            bit         bad;
            bit         aborted;
            int         idle;
            logic [2:0] act;
            skip = 1'b0;
            idle = 0;
            forever begin
                if (!skip) @(negedge clk);
                skip = 1'b0;
                if (rstn[g] !== 1'b1) begin
                    idle = 0;
                end else if (tx_w[g] === 1'b0) begin
                    idle = 0;
                    if (q.size() == 0) begin
                        check(1'b0, "unexpected_start", g, 0, 1);
                        for (int i = 0; i < 2 * F && tx_w[g] !== 1'b1; i++) @(negedge clk);
                    end else begin
                        e       = q.pop_front();
                        aborted = 1'b0;
                        for (int b = 0; b < e.n && !aborted; b++) begin
                            bad = 1'b0;
                            act = '0;
                            for (int c = 0; c < C; c++) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (rstn[g] !== 1'b1) begin
                                    aborted = 1'b1;
                                    break;
                                end
                                if (!bad && (tx_w[g] !== e.lv[b] || busy_w[g] !== 1'b1 || n_rd_w[g] !== 1'b1)) begin
                                    bad = 1'b1;
                                    act = {busy_w[g], n_rd_w[g], tx_w[g]};
                                end
                            end
                            if (!aborted) begin
                                check(!bad, $sformatf("frame_bit%0d", b), g, int'(act), int'({2'b11, e.lv[b]}));
                            end
                        end
                        if (!aborted) begin
                            @(negedge clk);
                            if (rstn[g] === 1'b1) begin
                                if (q.size() > 0 && q[0].chained) begin
                                    check(tx_w[g] === 1'b0 && busy_w[g] === 1'b1, "chain_start", g,
                                          int'({busy_w[g], tx_w[g]}), 2);
                                    skip = 1'b1;
                                end else begin
                                    check(tx_w[g] === 1'b1 && busy_w[g] === 1'b0 && n_rd_w[g] === 1'b0,
                                          "frame_end", g, int'({tx_w[g], busy_w[g], n_rd_w[g]}), 4);
                                end
                            end
                        end
                    end
                end else if (q.size() > 0) begin
                    idle++;
                    if (idle > 2 * F) begin
                        check(1'b0, "start_timeout", g, idle, 2 * F);
                        e    = q.pop_front();
                        idle = 0;
                    end
                end
            end
        end
    end

    initial begin : main
        int t;
        bit all;
        t   = 0;
        all = 1'b0;
        while (!all && t < 20000) begin
            @(negedge clk);
            t++;
            all = 1'b1;
            for (int i = 0; i < NCFG; i++) begin
                if (!done[i]) all = 1'b0;
            end
        end
        check(all, "all_done", 0, t, 20000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
